key_frame_tx: RTL and testbench
===============================

KEY_FRAME_TX -- requirements
Module: key_frame_tx

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 61: number of key inputs (1..512).
REQ-002 SHALL have parameter CLK_DIV, default 2: clk_g_i cycles per SCK half-period (>=1).
REQ-003 SHALL have parameter HEARTBEAT_CYCLES, default 0: idle cycles before an unsolicited frame; 0 disables the heartbeat.
REQ-004 SHALL have parameter CS_GAP, default 4: minimum chip-select-high cycles between frames (>=1).
REQ-005 SHALL have parameter HEADER, default 8'hA5: first byte of every frame.
REQ-006 SHALL have one clock and synchronous active-low reset: clk_g_i and rstn_g_i.
REQ-007 SHALL have ports, in order:
- clk_g_i  in  1  sole clock
- rstn_g_i  in  1  synchronous active-low reset
- keys_i  in  NUM_KEYS  debounced key levels, synchronous to clk_g_i, 1 = released
- enable_i  in  1  permits new frames to start
- spi_clk_o  out  1  SCK, mode 0 (idle low)
- spi_mosi_o  out  1  serial data, MSB first
- spi_cs_n_o  out  1  frame chip select, active low
- busy_o  out  1  high from frame start through end of gap
- frame_done_o  out  1  one-cycle pulse at end of each frame
- seq_o  out  8  sequence number of the next frame

Function
REQ-008 SHALL define GROUPS = ceil(NUM_KEYS/8); frame = HEADER, SEQ, GROUPS key bytes, CRC; GROUPS+3 bytes total.
REQ-009 SHALL map key byte k = keys[8k+7:8k]; unused high bits of the last byte SHALL be 0.
REQ-010 SHALL compute CRC as CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over SEQ and key bytes, excluding HEADER.
REQ-011 SHALL use states IDLE, SHIFT, HOLD, GAP.
REQ-012 In IDLE with enable_i=1, SHALL start a frame when keys_i != last_sent or when the heartbeat is due; last_sent SHALL reset to all ones.
- A start SHALL snapshot keys_i into last_sent in the same cycle.
- All key bytes SHALL come from that snapshot.
REQ-013 Start cycle t:
- t+1: spi_cs_n_o=0, busy_o=1, first MOSI bit valid.
- SCK SHALL rise CLK_DIV cycles after each MOSI update and fall CLK_DIV cycles later.
- MOSI SHALL update on each falling edge.
- Bytes SHALL be back-to-back, 8*(GROUPS+3) SCK pulses.
REQ-014 After the final falling edge, SHALL enter HOLD for CLK_DIV cycles with CS low, then raise spi_cs_n_o and pulse frame_done_o in the same cycle, entering GAP.
REQ-015 GAP SHALL last CS_GAP cycles with busy_o=1, then return to IDLE with busy_o=0.
REQ-016 seq_o SHALL increment by 1 (mod 256, 255 wraps to 0) in the frame_done_o cycle; the frame carries the pre-increment value.
REQ-017 Key changes during a frame SHALL NOT alter it. Re-comparison occurs only in IDLE: a net change triggers the next frame; a change reverted before IDLE SHALL NOT.
REQ-018 Heartbeat counter:
- Clears at every frame start.
- Counts only in IDLE.
- When it reaches HEARTBEAT_CYCLES-1, heartbeat is due.
- A change and heartbeat coinciding SHALL produce one frame.
REQ-019 enable_i=0 SHALL block new starts only; a frame in progress SHALL complete, and a pending change SHALL be sent once enable_i returns high.
REQ-020 spi_mosi_o SHALL be 0 whenever spi_cs_n_o=1.

Reset
REQ-021 With rstn_g_i=0 at a clk_g_i edge, SHALL set: state IDLE, spi_cs_n_o=1, spi_clk_o=0, spi_mosi_o=0, busy_o=0, frame_done_o=0, seq_o=0, last_sent all ones, heartbeat counter 0, CRC 0.
REQ-022 Reset mid-frame SHALL abort it (CS high next edge, no frame_done_o pulse); the first post-reset frame SHALL carry SEQ 0.

Verification
REQ-023 Reset: hold rstn_g_i=0 for 3 cycles -> outputs per REQ-021; keys_i all ones, 1000 cycles -> no CS activity.
REQ-024 Single frame: NUM_KEYS=61, CLK_DIV=2; clear keys_i[0] -> 11 bytes A5,00,FE,FF,FF,FF,FF,FF,FF,1F,CRC.
- CRC equals the model's CRC-8 over 00,FE,FF×6,1F.
- 88 SCK pulses, 4 cycles per bit.
- frame_done_o 2 cycles after the last fall; seq_o then = 1.
REQ-025 Mid-frame change: change keys_i[60] during byte 3 -> current frame unchanged; second frame with SEQ 01 and updated byte starts the cycle after GAP (CS high exactly CS_GAP+1 cycles). A press-and-release within a frame -> no second frame.
REQ-026 Heartbeat: HEARTBEAT_CYCLES=500, static keys -> identical-content frames, SEQ incrementing, starts spaced frame+gap+500 cycles; HEARTBEAT_CYCLES=0 -> none.
REQ-027 Enable and wrap:
- enable_i=0 with a change -> no frame; enable_i=1 -> frame next cycle.
- 256 heartbeat frames -> SEQ 255 then 00.
- Reset during SHIFT -> CS high next edge, next frame SEQ 00.

Source files
------------

// File: rtl/key_frame_tx.sv
// Serialises the key matrix state as an SPI frame: HEADER, SEQ, key bytes, CRC-8.
// A frame goes out when the keys change or the heartbeat timer expires.
//  state | meaning
//  IDLE  | CS high; compare keys against the last snapshot, run the heartbeat timer
//  SHIFT | CS low; shift the frame out MSB first, SCK mode 0
//  HOLD  | CS low for CLK_DIV cycles after the final SCK fall
//  GAP   | CS high for CS_GAP cycles, busy still asserted
module key_frame_tx #(
    parameter int         NUM_KEYS         = 61,
    parameter int         CLK_DIV          = 2,
    parameter int         HEARTBEAT_CYCLES = 0,
    parameter int         CS_GAP           = 4,
    parameter logic [7:0] HEADER           = 8'hA5
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                enable_i,
    output logic                spi_clk_o,
    output logic                spi_mosi_o,
    output logic                spi_cs_n_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [7:0]          seq_o
);

    localparam int GROUPS = (NUM_KEYS + 7) / 8;
    localparam int NBYTES = GROUPS + 3;
    localparam int BYTE_W = $clog2(NBYTES);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int HB_W   = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(CS_GAP - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] last_sent_q, last_sent_d;
    logic [7:0]          seq_q, seq_d;
    logic [7:0]          crc_q, crc_d;
    logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic                sck_q, sck_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [HB_W-1:0]     hb_q, hb_d;
    logic                done_q, done_d;

    logic [8*GROUPS-1:0] key_pad;
    logic [7:0]          cur_byte;
    logic                cur_bit;
    logic [7:0]          crc_next;
    logic                hb_due;
    logic                start;

    always_comb begin
        key_pad = '0;
        key_pad[NUM_KEYS-1:0] = last_sent_q;
        if (byte_idx_q == '0) begin
            cur_byte = HEADER;
        end else if (byte_idx_q == BYTE_W'(1)) begin
            cur_byte = seq_q;
        end else begin
            cur_byte = crc_q;
        end
        for (int g = 0; g < GROUPS; g++) begin
            if (byte_idx_q == BYTE_W'(g + 2)) cur_byte = key_pad[g*8 +: 8];
        end
    end

    // CRC advances one bit per SCK fall, so it is complete when the CRC byte begins.
    assign cur_bit  = cur_byte[3'd7 - bit_idx_q];
    assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cur_bit) ? 8'h07 : 8'h00);
    assign hb_due   = (HEARTBEAT_CYCLES != 0) && (hb_q == HB_LAST);
    assign start    = (state_q == IDLE) && enable_i && ((keys_i != last_sent_q) || hb_due);

    always_comb begin
        state_d     = state_q;
        last_sent_d = last_sent_q;
        seq_d       = seq_q;
        crc_d       = crc_q;
        byte_idx_d  = byte_idx_q;
        bit_idx_d   = bit_idx_q;
        sck_d       = sck_q;
        div_d       = div_q;
        gap_d       = gap_q;
        hb_d        = hb_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SHIFT;
                    last_sent_d = keys_i;
                    hb_d        = '0;
                    crc_d       = '0;
                    byte_idx_d  = '0;
                    bit_idx_d   = '0;
                    sck_d       = 1'b0;
                    div_d       = DIV_LOAD;
                end else if (!hb_due) begin
                    hb_d = hb_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d     = 1'b0;
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (byte_idx_q != '0 && byte_idx_q != LAST_BYTE) crc_d = crc_next;
                        if (bit_idx_q == 3'd7) begin
                            if (byte_idx_q == LAST_BYTE) state_d = HOLD;
                            else byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    state_d = GAP;
                    done_d  = 1'b1;
                    seq_d   = seq_q + 8'd1;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_g_i) begin
        if (!rstn_g_i) begin
            state_q     <= IDLE;
            last_sent_q <= '1;
            seq_q       <= '0;
            crc_q       <= '0;
            byte_idx_q  <= '0;
            bit_idx_q   <= '0;
            sck_q       <= 1'b0;
            div_q       <= '0;
            gap_q       <= '0;
            hb_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_sent_q <= last_sent_d;
            seq_q       <= seq_d;
            crc_q       <= crc_d;
            byte_idx_q  <= byte_idx_d;
            bit_idx_q   <= bit_idx_d;
            sck_q       <= sck_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            hb_q        <= hb_d;
            done_q      <= done_d;
        end
    end

    assign spi_clk_o    = sck_q;
    assign spi_mosi_o   = (state_q == SHIFT) & cur_bit;
    assign spi_cs_n_o   = !((state_q == SHIFT) || (state_q == HOLD));
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign seq_o        = seq_q;

endmodule

// File: tb/tb_key_frame_tx.sv
// Directed bench for key_frame_tx: three instances cover the default frame,
// a 500-cycle heartbeat, and a small fast configuration for sequence wrap.
module tb_key_frame_tx;

    logic clk;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    logic        rstn_a, rstn_bc;
    logic [60:0] keys_a, keys_b;
    logic [7:0]  keys_c;
    logic        en_a, en_b, en_c;
    logic        sck_a, mosi_a, cs_a, busy_a, done_a;
    logic        sck_b, mosi_b, cs_b, busy_b, done_b;
    logic        sck_c, mosi_c, cs_c, busy_c, done_c;
    logic [7:0]  seq_a, seq_b, seq_c;

    key_frame_tx #(.NUM_KEYS(61), .CLK_DIV(2), .HEARTBEAT_CYCLES(0), .CS_GAP(4), .HEADER(8'hA5)) dut_a (
        .clk_g_i(clk), .rstn_g_i(rstn_a), .keys_i(keys_a), .enable_i(en_a),
        .spi_clk_o(sck_a), .spi_mosi_o(mosi_a), .spi_cs_n_o(cs_a),
        .busy_o(busy_a), .frame_done_o(done_a), .seq_o(seq_a));

    key_frame_tx #(.NUM_KEYS(61), .CLK_DIV(2), .HEARTBEAT_CYCLES(500), .CS_GAP(4), .HEADER(8'hA5)) dut_b (
        .clk_g_i(clk), .rstn_g_i(rstn_bc), .keys_i(keys_b), .enable_i(en_b),
        .spi_clk_o(sck_b), .spi_mosi_o(mosi_b), .spi_cs_n_o(cs_b),
        .busy_o(busy_b), .frame_done_o(done_b), .seq_o(seq_b));

    key_frame_tx #(.NUM_KEYS(8), .CLK_DIV(1), .HEARTBEAT_CYCLES(4), .CS_GAP(1), .HEADER(8'hA5)) dut_c (
        .clk_g_i(clk), .rstn_g_i(rstn_bc), .keys_i(keys_c), .enable_i(en_c),
        .spi_clk_o(sck_c), .spi_mosi_o(mosi_c), .spi_cs_n_o(cs_c),
        .busy_o(busy_c), .frame_done_o(done_c), .seq_o(seq_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int sel = 0;
    logic mon_cs_n, mon_sck, mon_mosi, mon_done;
    always_comb begin
        case (sel)
            0:       begin mon_cs_n = cs_a; mon_sck = sck_a; mon_mosi = mosi_a; mon_done = done_a; end
            1:       begin mon_cs_n = cs_b; mon_sck = sck_b; mon_mosi = mosi_b; mon_done = done_b; end
            default: begin mon_cs_n = cs_c; mon_sck = sck_c; mon_mosi = mosi_c; mon_done = done_c; end
        endcase
    end

    int csl_a = 0;
    int viol = 0;
    always @(negedge clk) begin
        if (cs_a === 1'b0) csl_a <= csl_a + 1;
        if ((cs_a === 1'b1 && mosi_a === 1'b1) || (cs_b === 1'b1 && mosi_b === 1'b1) ||
            (cs_c === 1'b1 && mosi_c === 1'b1)) viol <= viol + 1;
    end

    logic [7:0] cap_bytes [16];
    logic [7:0] exp_bytes [16];
    int cap_found, cap_pulses, cap_low_cyc, cap_first_rise, cap_last_rise, cap_last_fall, cap_end_cyc, cap_done_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_exp(input int n);
        logic [7:0] c = 8'h00;
        for (int i = 1; i < n - 1; i++) begin
            c = c ^ exp_bytes[i];
            for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Waits for CS low, then records one frame; keys_a may be rewritten at given SCK pulse numbers.
    task automatic capture(input int max_wait, input int inj_p1, input logic [60:0] inj_k1,
                           input int inj_p2, input logic [60:0] inj_k2);
        int w;
        logic [7:0] sh;
        logic prev_sck;
        cap_found = 0; cap_pulses = 0; cap_done_ok = 0;
        for (int i = 0; i < 16; i++) cap_bytes[i] = 8'h00;
        w = 0;
        while (mon_cs_n !== 1'b0 && w < max_wait) begin @(negedge clk); w++; end
        if (mon_cs_n !== 1'b0) return;
        cap_found = 1; cap_low_cyc = cyc; prev_sck = 1'b0; sh = 8'h00; w = 0;
        while (mon_cs_n === 1'b0 && w < 5000) begin
            if (mon_sck === 1'b1 && prev_sck === 1'b0) begin
                sh = {sh[6:0], mon_mosi};
                cap_pulses++;
                if (cap_pulses == 1) cap_first_rise = cyc;
                cap_last_rise = cyc;
                if (cap_pulses % 8 == 0 && cap_pulses <= 128) cap_bytes[cap_pulses/8 - 1] = sh;
                if (cap_pulses == inj_p1) keys_a = inj_k1;
                if (cap_pulses == inj_p2) keys_a = inj_k2;
            end
            if (mon_sck === 1'b0 && prev_sck === 1'b1) cap_last_fall = cyc;
            prev_sck = mon_sck;
            @(negedge clk);
            w++;
        end
        cap_end_cyc = cyc;
        cap_done_ok = (mon_done === 1'b1) ? 1 : 0;
    endtask

    task automatic set_exp_61(input logic [7:0] s, input logic [7:0] b2, input logic [7:0] b9);
        exp_bytes[0] = 8'hA5; exp_bytes[1] = s; exp_bytes[2] = b2;
        for (int i = 3; i < 9; i++) exp_bytes[i] = 8'hFF;
        exp_bytes[9] = b9;
    endtask

    task automatic check_cap(input string tag, input int n, input int div);
        exp_bytes[n-1] = crc8_exp(n);
        chk({tag, ".found"}, 32'(cap_found), 1);
        for (int i = 0; i < n; i++) chk($sformatf("%s.byte%0d", tag, i), 32'(cap_bytes[i]), 32'(exp_bytes[i]));
        chk({tag, ".pulses"}, 32'(cap_pulses), 32'(8 * n));
        chk({tag, ".first_rise"}, 32'(cap_first_rise - cap_low_cyc), 32'(div));
        chk({tag, ".bit_period"}, 32'(cap_last_rise - cap_first_rise), 32'(2 * div * (8 * n - 1)));
        chk({tag, ".hold"}, 32'(cap_end_cyc - cap_last_fall), 32'(div));
        chk({tag, ".done"}, 32'(cap_done_ok), 1);
    endtask

    int t0, t_rel, w;
    logic [60:0] k, k2;

    initial begin
        rstn_a = 1'b0; rstn_bc = 1'b0;
        keys_a = '1; keys_b = '1; keys_c = '1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.cs_n", 32'(cs_a), 1);
        chk("rst.sck", 32'(sck_a), 0);
        chk("rst.mosi", 32'(mosi_a), 0);
        chk("rst.busy", 32'(busy_a), 0);
        chk("rst.done", 32'(done_a), 0);
        chk("rst.seq", 32'(seq_a), 0);
        chk("rst.cs_n_b", 32'(cs_b), 1);
        rstn_a = 1'b1; rstn_bc = 1'b1; t_rel = cyc;

        // heartbeat: first frame after 500 idle cycles, then one every 858 cycles
        sel = 1;
        capture(1000, 0, keys_a, 0, keys_a);
        chk("hb1.start", 32'(cap_low_cyc - t_rel), 500);
        set_exp_61(8'h00, 8'hFF, 8'h1F); check_cap("hb1", 11, 2);
        t0 = cap_low_cyc;
        capture(1000, 0, keys_a, 0, keys_a);
        chk("hb2.spacing", 32'(cap_low_cyc - t0), 858);
        set_exp_61(8'h01, 8'hFF, 8'h1F); check_cap("hb2", 11, 2);
        chk("a.idle_no_cs", 32'(csl_a), 0);

        // single key press
        sel = 0;
        keys_a[0] = 1'b0; t0 = cyc;
        capture(20, 0, keys_a, 0, keys_a);
        chk("f0.start", 32'(cap_low_cyc - t0), 1);
        set_exp_61(8'h00, 8'hFE, 8'h1F); check_cap("f0", 11, 2);
        chk("f0.seq_o", 32'(seq_a), 1);
        repeat (3) @(negedge clk);
        chk("f0.busy_gap", 32'(busy_a), 1);
        @(negedge clk);
        chk("f0.busy_idle", 32'(busy_a), 0);

        // change during byte 3 is held for the next frame
        keys_a[1] = 1'b0; k = keys_a; k[60] = 1'b0;
        capture(20, 25, k, 0, k);
        set_exp_61(8'h01, 8'hFC, 8'h1F); check_cap("f1", 11, 2);
        t0 = cap_end_cyc;
        capture(20, 0, keys_a, 0, keys_a);
        chk("f2.cs_high", 32'(cap_low_cyc - t0), 5);
        set_exp_61(8'h02, 8'hFC, 8'h0F); check_cap("f2", 11, 2);

        // press and release inside a frame leaves no net change
        keys_a[2] = 1'b0; k = keys_a; k2 = keys_a; k[5] = 1'b0;
        capture(20, 10, k, 40, k2);
        set_exp_61(8'h03, 8'hF8, 8'h0F); check_cap("f3", 11, 2);
        capture(200, 0, keys_a, 0, keys_a);
        chk("f3.no_retrigger", 32'(cap_found), 0);

        // enable gating
        en_a = 1'b0; keys_a[3] = 1'b0;
        capture(50, 0, keys_a, 0, keys_a);
        chk("en.blocked", 32'(cap_found), 0);
        en_a = 1'b1; t0 = cyc;
        capture(20, 0, keys_a, 0, keys_a);
        chk("en.start", 32'(cap_low_cyc - t0), 1);
        set_exp_61(8'h04, 8'hF0, 8'h0F); check_cap("f4", 11, 2);

        // reset in the middle of SHIFT
        keys_a[4] = 1'b0; w = 0;
        while (cs_a !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        chk("rst2.started", 32'(cs_a), 0);
        repeat (30) @(negedge clk);
        rstn_a = 1'b0;
        @(negedge clk);
        chk("rst2.cs_n", 32'(cs_a), 1);
        chk("rst2.sck", 32'(sck_a), 0);
        chk("rst2.mosi", 32'(mosi_a), 0);
        chk("rst2.busy", 32'(busy_a), 0);
        chk("rst2.done", 32'(done_a), 0);
        chk("rst2.seq", 32'(seq_a), 0);
        @(negedge clk);
        chk("rst2.done2", 32'(done_a), 0);
        rstn_a = 1'b1; t0 = cyc;
        capture(20, 0, keys_a, 0, keys_a);
        chk("f5.start", 32'(cap_low_cyc - t0), 1);
        set_exp_61(8'h00, 8'hE0, 8'h0F); check_cap("f5", 11, 2);

        // sequence wrap on the small heartbeat instance
        w = 0;
        while (seq_c !== 8'hFF && w < 30000) begin @(negedge clk); w++; end
        chk("wrap.reach_ff", 32'(seq_c), 32'h0FF);
        sel = 2;
        capture(200, 0, keys_a, 0, keys_a);
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'hFF;
        check_cap("wrap_ff", 4, 1);
        chk("wrap.seq_o", 32'(seq_c), 0);
        capture(200, 0, keys_a, 0, keys_a);
        exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hFF;
        check_cap("wrap_00", 4, 1);

        chk("mosi_idle_low", 32'(viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
